ps2_rx: RTL and testbench

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_rx_if.sv | 40 ++++
 rtl/ps2_rx.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_rx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx_if
//  Description : Consumer-side bundle of the PS/2 receiver. Carries the FIFO
//                head byte, its valid/ready handshake, the occupancy count
//                and the three one-cycle status pulses.
//                  data        head byte (meaningful only while valid=1)
//                  valid       FIFO non-empty
//                  ready       consumer takes the head byte on valid&ready
//                  parity_err  frame dropped for bad odd parity
//                  frame_err   frame dropped for bad stop bit or timeout
//                  overflow    good byte dropped because the FIFO was full
//                  count       FIFO occupancy, 0..FIFO_DEPTH
//                master = receiver side, slave = consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface ps2_rx_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    data;
    logic          valid;
    logic          ready;
    logic          parity_err;
    logic          frame_err;
    logic          overflow;
    logic [CW-1:0] count;

    modport master (
        output data, valid, parity_err, frame_err, overflow, count,
        input  ready
    );

    modport slave (
        input  data, valid, parity_err, frame_err, overflow, count,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx
//  Description : PS/2 device-to-host receiver. Synchronises and glitch-filters
//                ps2_clk, samples ps2_dat on each filtered falling edge,
//                assembles 11-bit frames (start, 8 data LSB-first, odd parity,
//                stop), checks them and queues good bytes in a small FIFO.
//  Ports       : clk100   sole clock (rising edge)
//                rst_n    asynchronous active-low reset
//                ps2_clk  asynchronous PS/2 clock, idle high
//                ps2_dat  asynchronous PS/2 data, idle high
//                rx       ps2_rx_if.master: data/valid/ready/count + pulses
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FIFO_DEPTH     = 8
) (
    input  wire       clk100,
    input  wire       rst_n,
    input  wire       ps2_clk,
    input  wire       ps2_dat,
    ps2_rx_if.master  rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // ------------------------------------------------------------------
    // Input synchronisers (idle-high lines, so flops reset to 1)
    // ------------------------------------------------------------------
    logic clk_s1, clk_s2, dat_s1, dat_s2;

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // ------------------------------------------------------------------
    // Clock filter: follow the synchronised level only after it has
    // differed from the filtered level for FILTER_LEN straight cycles.
    // fall is registered together with the filtered level so it is high
    // during exactly the first cycle the filtered clock reads 0.
    // ------------------------------------------------------------------
    logic       filt_clk;
    logic [7:0] run_cnt;
    logic       fall;

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk <= 1'b1;
            run_cnt  <= 8'd0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 != filt_clk) begin
                if (run_cnt == 8'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    run_cnt  <= 8'd0;
                    fall     <= filt_clk & ~clk_s2;
                end else begin
                    run_cnt <= run_cnt + 8'd1;
                end
            end else begin
                run_cnt <= 8'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [1:0]  state, state_nxt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_bit;
    logic [19:0] to_cnt;
    logic        timeout;

    logic start_frame, shift_en, par_en;
    logic bad_stop, bad_par, good_frame;

    // A fall cycle always makes progress, so the watchdog only fires on
    // cycles without one.
    assign timeout = (state != S_IDLE) && !fall &&
                     (to_cnt == 20'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = S_IDLE;
        end else if (fall) begin
            case (state)
                S_IDLE:   if (!dat_s2) state_nxt = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        start_frame = fall && (state == S_IDLE) && !dat_s2;
        shift_en    = fall && (state == S_DATA);
        par_en      = fall && (state == S_PARITY);
        bad_stop    = 1'b0;
        bad_par     = 1'b0;
        good_frame  = 1'b0;
        if (fall && (state == S_STOP)) begin
            // Stop-bit error wins; parity is only judged on a clean stop.
            bad_stop   = !dat_s2;
            bad_par    = dat_s2 && !(^{shreg, par_bit});
            good_frame = dat_s2 &&  (^{shreg, par_bit});
        end
    end

    // Frame datapath and the registered result of the stop-bit decision.
    logic       push_pend;
    logic [7:0] push_byte;
    logic       parity_err_q, frame_err_q;

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= 3'd0;
            shreg        <= 8'd0;
            par_bit      <= 1'b0;
            to_cnt       <= 20'd0;
            push_pend    <= 1'b0;
            push_byte    <= 8'd0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (fall || (state == S_IDLE) || timeout) to_cnt <= 20'd0;
            else                                       to_cnt <= to_cnt + 20'd1;

            if (start_frame) begin
                bit_cnt <= 3'd0;
                shreg   <= 8'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {dat_s2, shreg[7:1]};
            end

            if (par_en) par_bit <= dat_s2;

            parity_err_q <= bad_par;
            frame_err_q  <= bad_stop || timeout;
            push_pend    <= good_frame;
            if (good_frame) push_byte <= shreg;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO. When full, a push is still accepted if the head is
    // popped on the same cycle (the freed slot is the one being written).
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          empty, full, pop, wr_en, overflow_q;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(FIFO_DEPTH));
    assign pop   = !empty && rx.ready;
    assign wr_en = push_pend && (!full || pop);

    always_ff @(posedge clk100) begin
        if (wr_en) mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            overflow_q <= push_pend && full && !pop;
        end
    end

    assign rx.data       = empty ? 8'h00 : mem[rd_ptr];
    assign rx.valid      = !empty;
    assign rx.count      = cnt;
    assign rx.parity_err = parity_err_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_rx
//  Description : Self-checking bench for ps2_rx. A queue-based model of the
//                receiver (frame -> good/parity/stop verdict -> FIFO of bytes)
//                is compared with the DUT every cycle, backed by literal
//                expectations at key points.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_rx;
    localparam int FL = 4;
    localparam int TO = 1000;
    localparam int FD = 4;
    localparam int H  = 40;      // half PS/2 bit period in clk100 cycles

    logic clk100  = 1'b0;
    logic rst_n   = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_rx_if #(.FIFO_DEPTH(FD)) rx ();

    ps2_rx #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk100 (clk100),
        .rst_n  (rst_n),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .rx     (rx)
    );

    always #5 clk100 = ~clk100;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cnt_pe = 0, cnt_fe = 0, cnt_ov = 0;
    int exp_pe = 0, exp_fe = 0, exp_ov = 0;
    int fe_cyc = 0;
    int last_fall_cyc = 0;
    bit check_en = 1'b0;
    logic [7:0] q[$];

    always @(posedge clk100) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    // Model: verdict of a complete frame from its bits alone.
    task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
        if (!stop)                 exp_fe++;
        else if (^{d, par} == 1'b0) exp_pe++;
        else if (q.size() == FD)   exp_ov++;
        else                       q.push_back(d);
    endtask

    // Drives nbits of the frame {stop, par, d, start}; glitch adds a 2-cycle
    // low spike in the high half of every bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            if (glitch) begin
                wait_cyc(H / 2);
                ps2_clk = 1'b0;
                wait_cyc(2);
                ps2_clk = 1'b1;
                wait_cyc(H / 2 - 2);
            end else begin
                wait_cyc(H);
            end
            if (i == 10) check_en = 1'b0;
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        if (nbits == 11) begin
            model_frame(d, par, stop);
            check_en = 1'b1;
        end
        ps2_dat = 1'b1;
        wait_cyc(H);
    endtask

    task automatic drain();
        rx.ready = 1'b1;
        wait_cyc(FD + 2);
        rx.ready = 1'b0;
        wait_cyc(1);
    endtask

    // Per-cycle compare against the model, plus pulse accounting.
    always @(negedge clk100) begin
        if (rst_n === 1'b1) begin
            if (rx.parity_err) cnt_pe++;
            if (rx.overflow)   cnt_ov++;
            if (rx.frame_err) begin
                cnt_fe++;
                fe_cyc = cyc;
            end
            if (rx.parity_err || rx.frame_err)
                chk("err_exclusive", 32'(rx.parity_err & rx.frame_err), 32'd0);
            if (check_en) begin
                chk("count", 32'(rx.count), 32'(q.size()));
                chk("valid", 32'(rx.valid), 32'(q.size() != 0));
                if (q.size() != 0) chk("data", 32'(rx.data), 32'(q[0]));
            end
            if (rx.ready && q.size() != 0) void'(q.pop_front());
        end
    end

    logic [7:0] pop_exp [4];
    logic [7:0] par_tab [5];

    initial begin
        int fe0, ov0, dly;
        rx.ready = 1'b0;
        pop_exp[0] = 8'h01; pop_exp[1] = 8'h02; pop_exp[2] = 8'h03; pop_exp[3] = 8'h04;
        // odd parity bits for 0x01..0x05
        par_tab[0] = 8'd0; par_tab[1] = 8'd0; par_tab[2] = 8'd1; par_tab[3] = 8'd0; par_tab[4] = 8'd1;

        // Reset state
        wait_cyc(3);
        chk("rst_valid", 32'(rx.valid), 32'd0);
        chk("rst_count", 32'(rx.count), 32'd0);
        chk("rst_data",  32'(rx.data),  32'd0);
        chk("rst_pulses", 32'({rx.parity_err, rx.frame_err, rx.overflow}), 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);
        check_en = 1'b1;

        // Good frame 0x1C, parity 0
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        wait_cyc(5);
        chk("t1_data",  32'(rx.data),  32'h1C);
        chk("t1_count", 32'(rx.count), 32'd1);
        chk("t1_valid", 32'(rx.valid), 32'd1);
        chk("t1_noerr", 32'(cnt_pe + cnt_fe), 32'd0);
        drain();

        // Bad parity, then bad stop bit
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        wait_cyc(5);
        chk("t2_parity_err", 32'(cnt_pe), 32'd1);
        chk("t2_valid", 32'(rx.valid), 32'd0);
        send_frame(8'h00, 1'b1, 1'b0, 11, 1'b0);
        wait_cyc(5);
        chk("t2_frame_err", 32'(cnt_fe), 32'd1);
        chk("t2_parity_err_once", 32'(cnt_pe), 32'd1);

        // Partial frame (start + 3 data bits) then timeout
        fe0 = cnt_fe;
        send_frame(8'h05, 1'b1, 1'b1, 4, 1'b0);
        for (int k = 0; k < 1200 && cnt_fe == fe0; k++) wait_cyc(1);
        exp_fe++;
        chk("t3_timeout_fired", 32'(cnt_fe), 32'(fe0 + 1));
        dly = fe_cyc - last_fall_cyc;
        if (!(dly >= 1000 && dly <= 1015)) begin
            n_bad++;
            $display("FAIL t3_timeout_delay: actual=%0d required=1000..1015", dly);
        end
        n_cmp++;
        chk("t3_valid", 32'(rx.valid), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b0);
        wait_cyc(5);
        chk("t3_data", 32'(rx.data), 32'h5A);
        drain();

        // Five frames into a 4-deep FIFO with ready low
        ov0 = cnt_ov;
        for (int v = 1; v <= 5; v++)
            send_frame(8'(v), par_tab[v-1][0], 1'b1, 11, 1'b0);
        wait_cyc(5);
        chk("t4_count", 32'(rx.count), 32'd4);
        chk("t4_overflow", 32'(cnt_ov), 32'(ov0 + 1));
        rx.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk100);
            chk("t4_pop_valid", 32'(rx.valid), 32'd1);
            chk("t4_pop_data",  32'(rx.data),  32'(pop_exp[i]));
            @(posedge clk100);
        end
        #1;
        rx.ready = 1'b0;
        wait_cyc(2);
        chk("t4_empty", 32'(rx.count), 32'd0);

        // Glitches: idle spike with data low must not start a frame
        fe0 = cnt_fe;
        ps2_dat = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        wait_cyc(5);
        ps2_dat = 1'b1;
        wait_cyc(1200);
        chk("t5_idle_glitch", 32'(cnt_fe), 32'(fe0));
        send_frame(8'hA7, 1'b0, 1'b1, 11, 1'b1);
        wait_cyc(5);
        chk("t5_data", 32'(rx.data), 32'hA7);
        chk("t5_count", 32'(rx.count), 32'd1);
        drain();

        // Reset mid-frame
        send_frame(8'h11, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h33, 1'b1, 1'b1, 5, 1'b0);
        check_en = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("t6_rst_valid", 32'(rx.valid), 32'd0);
        chk("t6_rst_count", 32'(rx.count), 32'd0);
        chk("t6_rst_data",  32'(rx.data),  32'd0);
        chk("t6_rst_pulses", 32'({rx.parity_err, rx.frame_err, rx.overflow}), 32'd0);
        q.delete();
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(5);
        check_en = 1'b1;
        send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
        wait_cyc(5);
        chk("t6_data",  32'(rx.data),  32'hF0);
        chk("t6_count", 32'(rx.count), 32'd1);

        chk("total_parity_err", 32'(cnt_pe), 32'(exp_pe));
        chk("total_frame_err",  32'(cnt_fe), 32'(exp_fe));
        chk("total_overflow",   32'(cnt_ov), 32'(exp_ov));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
